// File: rtl/int_ctrl_pkg.sv
// Shared core definitions: control-stage operation encodings used by the
// core FSM and the interrupt controller's configuration register map.
package int_ctrl_pkg;

   // Core FSM control-stage operations
   localparam logic [1:0] OP_TRAP     = 2'b00;
   localparam logic [1:0] OP_EXT_INT  = 2'b01;
   localparam logic [1:0] OP_SW_INT   = 2'b10;
   localparam logic [1:0] OP_NORMAL   = 2'b11;

   // Configuration register addresses
   localparam logic [1:0] CFG_ENABLE  = 2'd0;
   localparam logic [1:0] CFG_MODE    = 2'd1;
   localparam logic [1:0] CFG_PENDING = 2'd2;
   localparam logic [1:0] CFG_SW_PEND = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over a request vector.
module int_prio_enc #(
   parameter int N    = 8,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   output logic [ID_W-1:0] idx,
   output logic            any_valid
);

   // Scan upward; the first set bit wins and later bits are ignored
   always_comb begin
      idx       = '0;
      any_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !any_valid) begin
            idx       = ID_W'(i);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes external request lines, latches them
// into pending bits (edge or level per source), raises ext_int/sw_int to the
// core FSM and performs the claim handshake when the control stage starts.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_SRC-1:0]         irq_in,
   input  logic                       stage_control,
   input  logic [1:0]                 control_op,
   input  logic                       cfg_we,
   input  logic [1:0]                 cfg_addr,
   input  logic [NUM_SRC-1:0]         cfg_wdata,
   output logic [NUM_SRC-1:0]         cfg_rdata,
   output logic                       ext_int,
   output logic                       sw_int,
   output logic [$clog2(NUM_SRC)-1:0] claim_id,
   output logic                       claim_valid
);

   localparam int ID_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0] sync1, sync2, hist;
   logic [NUM_SRC-1:0] enable, mode, pending;
   logic [NUM_SRC-1:0] set_vec, w1c_vec, claim_clr, req;
   logic               sw_pend;
   logic               stage_d;
   logic               claim_start, claim_ext, claim_sw;
   logic [ID_W-1:0]    sel_id;
   logic               sel_valid;

   // Two-flop synchronizer plus edge history of the synchronized value
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         hist  <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   // Per-source set event: rising edge in edge mode, high level in level mode
   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         set_vec[i] = mode[i] ? (sync2[i] & ~hist[i]) : sync2[i];
      end
   end

   // Delay of stage_control for rising-edge claim detection
   always_ff @(posedge clk) begin
      if (!reset_n) stage_d <= 1'b0;
      else          stage_d <= stage_control;
   end

   assign claim_start = stage_control & ~stage_d;

   // Decode which claim action the starting control stage requests
   always_comb begin
      claim_ext = 1'b0;
      claim_sw  = 1'b0;
      if (claim_start) begin
         case (control_op)
            OP_EXT_INT:         claim_ext = 1'b1;
            OP_SW_INT:          claim_sw  = 1'b1;
            OP_TRAP, OP_NORMAL: ;
            default:            ;
         endcase
      end
   end

   assign req = pending & enable;

   int_prio_enc #(
      .N    (NUM_SRC),
      .ID_W (ID_W)
   ) u_prio (
      .req       (req),
      .idx       (sel_id),
      .any_valid (sel_valid)
   );

   // Clear masks from a W1C write and from a successful external claim
   always_comb begin
      w1c_vec   = (cfg_we && cfg_addr == CFG_PENDING) ? cfg_wdata : '0;
      claim_clr = '0;
      if (claim_ext && sel_valid) claim_clr[sel_id] = 1'b1;
   end

   // Pending bits: set events take precedence over same-cycle clears
   always_ff @(posedge clk) begin
      if (!reset_n) pending <= '0;
      else          pending <= (pending & ~(w1c_vec | claim_clr)) | set_vec;
   end

   // Enable/mode registers replaced by configuration writes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable <= '0;
         mode   <= '0;
      end else if (cfg_we) begin
         if (cfg_addr == CFG_ENABLE) enable <= cfg_wdata;
         if (cfg_addr == CFG_MODE)   mode   <= cfg_wdata;
      end
   end

   // Software pending: a write wins over a same-cycle software claim
   always_ff @(posedge clk) begin
      if (!reset_n)                             sw_pend <= 1'b0;
      else if (cfg_we && cfg_addr == CFG_SW_PEND) sw_pend <= cfg_wdata[0];
      else if (claim_sw)                        sw_pend <= 1'b0;
   end

   // Claim result: id updates only when an enabled pending source exists
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         claim_id    <= '0;
         claim_valid <= 1'b0;
      end else begin
         claim_valid <= claim_ext & sel_valid;
         if (claim_ext && sel_valid) claim_id <= sel_id;
      end
   end

   // Combinational register readback
   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         CFG_ENABLE:  cfg_rdata    = enable;
         CFG_MODE:    cfg_rdata    = mode;
         CFG_PENDING: cfg_rdata    = pending;
         CFG_SW_PEND: cfg_rdata[0] = sw_pend;
         default:     ;
      endcase
   end

   assign ext_int = |req;
   assign sw_int  = sw_pend;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with NUM_SRC = 8.
module tb_int_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irq_in;
   logic       stage_control;
   logic [1:0] control_op;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       ext_int, sw_int;
   logic [2:0] claim_id;
   logic       claim_valid;

   int n_cmp = 0;
   int n_err = 0;

   int_ctrl #(.NUM_SRC(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .irq_in        (irq_in),
      .stage_control (stage_control),
      .control_op    (control_op),
      .cfg_we        (cfg_we),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .cfg_rdata     (cfg_rdata),
      .ext_int       (ext_int),
      .sw_int        (sw_int),
      .claim_id      (claim_id),
      .claim_valid   (claim_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_we    = 1'b0;
   endtask

   logic [7:0] r;

   initial begin
      reset_n = 1'b0; irq_in = '0; stage_control = 1'b0; control_op = 2'b11;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("rst_ext_int", ext_int, 0);
      check("rst_sw_int", sw_int, 0);
      check("rst_claim_valid", claim_valid, 0);
      check("rst_claim_id", claim_id, 0);
      rd(2'd0, r); check("rst_enable", r, 8'h00);
      rd(2'd2, r); check("rst_pending", r, 8'h00);

      // enable all, all edge mode
      wr(2'd0, 8'hFF);
      wr(2'd1, 8'hFF);
      rd(2'd0, r); check("enable_rd", r, 8'hFF);
      rd(2'd1, r); check("mode_rd", r, 8'hFF);

      // irq_in[3] rises in cycle 0 -> ext_int in cycle 3
      irq_in = 8'h08;
      tick(); tick();
      check("ext_int_cyc2", ext_int, 0);
      tick();
      check("ext_int_cyc3", ext_int, 1);
      rd(2'd2, r); check("pending_08", r, 8'h08);

      irq_in = 8'h28;
      tick(); tick(); tick();
      rd(2'd2, r); check("pending_28", r, 8'h28);

      // external claim picks lowest index
      stage_control = 1'b1; control_op = 2'b01;
      tick();
      check("claim1_valid", claim_valid, 1);
      check("claim1_id", claim_id, 3);
      rd(2'd2, r); check("claim1_pending", r, 8'h20);
      check("claim1_ext_int", ext_int, 1);
      tick();
      check("claim1_pulse_end", claim_valid, 0);
      rd(2'd2, r); check("claim1_no_reclaim", r, 8'h20);
      stage_control = 1'b0;
      tick();
      stage_control = 1'b1;
      tick();
      check("claim2_valid", claim_valid, 1);
      check("claim2_id", claim_id, 5);
      check("claim2_ext_int", ext_int, 0);
      stage_control = 1'b0;
      tick();
      // claim with nothing pending
      stage_control = 1'b1;
      tick();
      check("claim3_valid", claim_valid, 0);
      check("claim3_id", claim_id, 5);
      stage_control = 1'b0;
      irq_in = 8'h00;
      tick(); tick(); tick();
      rd(2'd2, r); check("fall_no_pending", r, 8'h00);

      // level source 1: W1C re-sets while held high
      wr(2'd1, 8'hFD);
      irq_in = 8'h02;
      tick(); tick(); tick();
      rd(2'd2, r); check("level_pending", r, 8'h02);
      wr(2'd2, 8'h02);
      rd(2'd2, r); check("level_w1c_reset", r, 8'h02);
      // edge mode: W1C sticks
      wr(2'd1, 8'hFF);
      rd(2'd2, r); check("mode_chg_hold", r, 8'h02);
      wr(2'd2, 8'h02);
      rd(2'd2, r); check("edge_w1c", r, 8'h00);

      // edge on bit 2 coincident with W1C of bit 2
      irq_in = 8'h06;
      tick(); tick();
      wr(2'd2, 8'h04);
      rd(2'd2, r); check("set_beats_w1c", r, 8'h04);
      check("set_beats_w1c_ext", ext_int, 1);
      wr(2'd2, 8'h04);
      rd(2'd2, r); check("w1c_after_edge", r, 8'h00);

      // software interrupt
      wr(2'd3, 8'h01);
      check("sw_set", sw_int, 1);
      rd(2'd3, r); check("sw_rd", r, 8'h01);
      stage_control = 1'b1; control_op = 2'b11;
      tick();
      check("sw_op11_nochg", sw_int, 1);
      stage_control = 1'b0;
      tick();
      stage_control = 1'b1; control_op = 2'b10;
      tick();
      check("sw_claim_clr", sw_int, 0);
      stage_control = 1'b0;
      tick();
      // write and sw claim in same cycle: write wins
      stage_control = 1'b1; control_op = 2'b10;
      wr(2'd3, 8'h01);
      check("sw_write_wins", sw_int, 1);
      stage_control = 1'b0;
      tick();

      // reset during claim with everything pending
      wr(2'd1, 8'h00);
      irq_in = 8'hFF;
      tick(); tick(); tick();
      rd(2'd2, r); check("pending_ff", r, 8'hFF);
      stage_control = 1'b1; control_op = 2'b01; reset_n = 1'b0;
      tick();
      rd(2'd2, r); check("rst_claim_pending", r, 8'h00);
      check("rst_claim_valid2", claim_valid, 0);
      check("rst_claim_ext", ext_int, 0);
      check("rst_claim_sw", sw_int, 0);
      check("rst_claim_id2", claim_id, 0);
      // configuration write ignored while in reset
      stage_control = 1'b0;
      wr(2'd0, 8'hFF);
      reset_n = 1'b1;
      rd(2'd0, r); check("rst_ignores_we", r, 8'h00);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, meaning the number of external interrupt sources (2..32).
REQ-002 SHALL have port clk  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port irq_in  in  NUM_SRC  asynchronous interrupt request lines.
REQ-005 SHALL have port stage_control  in  1  core FSM control stage active (stage_active bit 0).
REQ-006 SHALL have port control_op  in  2  core FSM control operation: 00 trap, 01 ext_int, 10 sw_int, 11 normal.
REQ-007 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-008 SHALL have port cfg_addr  in  2  register select: 0 enable, 1 mode, 2 pending, 3 sw_pend.
REQ-009 SHALL have port cfg_wdata  in  NUM_SRC  configuration write data.
REQ-010 SHALL have port cfg_rdata  out  NUM_SRC  combinational read of register at cfg_addr; sw_pend reads in bit 0, other bits zero.
REQ-011 SHALL have port ext_int  out  1  external interrupt request to core FSM.
REQ-012 SHALL have port sw_int  out  1  software interrupt request to core FSM.
REQ-013 SHALL have port claim_id  out  $clog2(NUM_SRC)  index of last claimed external source.
REQ-014 SHALL have port claim_valid  out  1  one-cycle pulse when claim_id updated.

Function
REQ-015 SHALL pass each irq_in bit through a two-flop synchronizer; logic uses only the second-stage value.
REQ-016 SHALL, per source with mode bit 1 (edge), set pending on a 0->1 transition of the synchronized value.
REQ-017 SHALL, per source with mode bit 0 (level), set pending each cycle the synchronized value is 1; pending holds until cleared.
REQ-018 SHALL drive ext_int = OR of (pending AND enable), combinationally from registers; irq_in rise sampled in cycle 0 -> pending and ext_int high in cycle 3.
REQ-019 SHALL drive sw_int = sw_pend register value.
REQ-020 SHALL detect claim start as the first cycle stage_control is high after being low (stage_control registered one cycle).
REQ-021 SHALL, at claim start with control_op = 01, load claim_id with the lowest index i where pending[i] AND enable[i], clear pending[i], and pulse claim_valid.
REQ-022 SHALL, at claim start with control_op = 01 and no enabled pending source, leave claim_id and pending unchanged and not pulse claim_valid.
REQ-023 SHALL, at claim start with control_op = 10, clear sw_pend; control_op 00/11 SHALL cause no claim action.
REQ-024 SHALL implement writes: addr 0/1 replace enable/mode; addr 2 write-1-to-clear pending; addr 3 bit0 replaces sw_pend.
REQ-025 SHALL, when a set event and a clear (W1C or claim) hit the same pending bit in one cycle, keep the bit set.
REQ-026 SHALL, when a sw_pend write and a sw claim occur in one cycle, apply the write value.
REQ-027 SHALL not change pending on a mode change except by REQ-016/017 in following cycles; edge detector history register keeps updating regardless of mode.

Reset
REQ-028 SHALL, on reset_n low at a clock edge, clear enable, mode, pending, sw_pend, synchronizer and edge history flops, claim_id, claim_valid and the stage_control delay flop, so ext_int = sw_int = 0 the cycle after.
REQ-029 SHALL, when reset asserts mid-claim, discard the claim: claim_valid 0 and pending cleared.
REQ-030 SHALL ignore cfg_we and claim start in any cycle reset_n is low.

Structure
REQ-031 SHALL place control_op encodings and cfg register address constants in the shared core package used by the FSM.
REQ-032 SHALL implement the lowest-index priority selection as sub-module int_prio_enc (inputs request vector, outputs index and any-valid).

Verification
REQ-033 SHALL cover: reset, enable=0xFF mode=0xFF, irq_in[3] 0->1 at cycle 0 -> ext_int=1 at cycle 3, pending=0x08.
REQ-034 SHALL cover: pending=0x28 enabled, stage_control rises with control_op=01 -> claim_id=3, claim_valid 1 cycle, pending=0x20, ext_int stays 1.
REQ-035 SHALL cover: level source 1 held high, W1C pending=0x02 -> pending reads 0x02 again next cycle; edge source 1 W1C -> reads 0x00.
REQ-036 SHALL cover: edge event on bit 2 coincident with W1C of bit 2 -> pending[2]=1.
REQ-037 SHALL cover: sw_pend write 1 -> sw_int=1; claim start with control_op=10 -> sw_int=0 next cycle; claim with control_op=11 -> no change.
REQ-038 SHALL cover: reset_n low during claim cycle with pending=0xFF -> next cycle pending=0, claim_valid=0, ext_int=0.
